// File: rtl/width_pack_fifo_if.sv
// width_pack_fifo_if: narrow-write / wide-read bus of the packing FIFO
//   wr_en, wr_data, wr_flush        -> FIFO  narrow write side, partial-word flush
//   wr_full, almost_full, wr_water_level   <- FIFO  write-side status (level in narrow words)
//   rd_en                           -> FIFO  wide read request
//   rd_data, rd_lanes, rd_valid     <- FIFO  wide word, valid-lane tag, one-cycle strobe
//   rd_empty, almost_empty, rd_water_level <- FIFO  read-side status (level in wide entries)
interface width_pack_fifo_if #(
    parameter int WR_DATA_WIDTH  = 16,
    parameter int RATIO          = 8,
    parameter int RD_DEPTH_WIDTH = 9
);
    localparam int LW  = $clog2(RATIO);
    localparam int RDW = WR_DATA_WIDTH * RATIO;
    logic                         wr_en;
    logic [WR_DATA_WIDTH-1:0]     wr_data;
    logic                         wr_flush;
    logic                         wr_full;
    logic                         almost_full;
    logic [RD_DEPTH_WIDTH+LW:0]   wr_water_level;
    logic                         rd_en;
    logic [RDW-1:0]               rd_data;
    logic [LW:0]                  rd_lanes;
    logic                         rd_valid;
    logic                         rd_empty;
    logic                         almost_empty;
    logic [RD_DEPTH_WIDTH:0]      rd_water_level;
    modport master (
        output wr_en, wr_data, wr_flush, rd_en,
        input  wr_full, almost_full, wr_water_level,
               rd_data, rd_lanes, rd_valid, rd_empty, almost_empty, rd_water_level
    );
    modport slave (
        input  wr_en, wr_data, wr_flush, rd_en,
        output wr_full, almost_full, wr_water_level,
               rd_data, rd_lanes, rd_valid, rd_empty, almost_empty, rd_water_level
    );
endinterface

// File: rtl/width_pack_fifo.sv
// width_pack_fifo: single-clock FIFO packing RATIO narrow words into one wide entry
//   clk    single clock for both sides
//   rst_n  synchronous active-low reset (RAM contents are kept)
//   bus    width_pack_fifo_if slave: narrow write/flush side, wide read side, status
module width_pack_fifo #(
    parameter int WR_DATA_WIDTH    = 16,
    parameter int RATIO            = 8,
    parameter int RD_DEPTH_WIDTH   = 9,
    parameter int ALMOST_FULL_NUM  = 4088,
    parameter int ALMOST_EMPTY_NUM = 4,
    parameter int LSB_FIRST        = 1
) (
    input logic clk,
    input logic rst_n,
    width_pack_fifo_if.slave bus
);
    localparam int LW    = $clog2(RATIO);
    localparam int DEPTH = 1 << RD_DEPTH_WIDTH;
    localparam int RDW   = WR_DATA_WIDTH * RATIO;
    localparam int CW    = RD_DEPTH_WIDTH + 1;
    localparam int WLW   = RD_DEPTH_WIDTH + LW + 1;

    logic [RDW-1:0]            mem     [DEPTH];
    logic [LW:0]               tag_mem [DEPTH];
    logic [RD_DEPTH_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]             ram_count;
    logic [LW-1:0]             lane_cnt, lane_idx;
    logic [RDW-1:0]            pack, pack_nx;
    logic [LW:0]               tag;
    logic                      full, empty, wr_acc, rd_acc, commit;

    assign full     = ram_count == CW'(DEPTH);
    assign empty    = ram_count == '0;
    assign wr_acc   = bus.wr_en && !full;
    assign rd_acc   = bus.rd_en && !empty;
    assign commit   = (wr_acc && lane_cnt == LW'(RATIO - 1)) ||
                      (bus.wr_flush && !full && (lane_cnt != '0 || wr_acc));
    assign tag      = {1'b0, lane_cnt} + (LW + 1)'(wr_acc);
    // RATIO is a power of two, so ~lane_cnt == RATIO-1-lane_cnt
    assign lane_idx = (LSB_FIRST != 0) ? lane_cnt : ~lane_cnt;

    assign bus.wr_full        = full;
    assign bus.rd_empty       = empty;
    // ram_count*RATIO + lane_cnt is just the concatenation
    assign bus.wr_water_level = {ram_count, lane_cnt};
    assign bus.almost_full    = {ram_count, lane_cnt} >= WLW'(ALMOST_FULL_NUM);
    assign bus.almost_empty   = ram_count <= CW'(ALMOST_EMPTY_NUM);
    assign bus.rd_water_level = ram_count;

    always_comb begin
        pack_nx = pack;
        for (int i = 0; i < RATIO; i++)
            if (wr_acc && lane_idx == LW'(i)) pack_nx[i*WR_DATA_WIDTH +: WR_DATA_WIDTH] = bus.wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            ram_count    <= '0;
            lane_cnt     <= '0;
            pack         <= '0;
            bus.rd_data  <= '0;
            bus.rd_lanes <= '0;
            bus.rd_valid <= 1'b0;
        end else begin
            if (commit) begin
                wr_ptr   <= wr_ptr + RD_DEPTH_WIDTH'(1);
                lane_cnt <= '0;
                pack     <= '0;
            end else begin
                lane_cnt <= lane_cnt + LW'(wr_acc);
                pack     <= pack_nx;
            end
            if (rd_acc) begin
                bus.rd_data  <= mem[rd_ptr];
                bus.rd_lanes <= tag_mem[rd_ptr];
                rd_ptr       <= rd_ptr + RD_DEPTH_WIDTH'(1);
            end
            bus.rd_valid <= rd_acc;
            ram_count    <= (commit && !rd_acc) ? ram_count + CW'(1) :
                            (!commit && rd_acc) ? ram_count - CW'(1) : ram_count;
        end
    end

    // unused lanes are already zero because the pack register clears on commit
    always_ff @(posedge clk) begin
        if (rst_n && commit) begin
            mem[wr_ptr]     <= pack_nx;
            tag_mem[wr_ptr] <= tag;
        end
    end
endmodule
